// File: rtl/iir_inv_cascade_pkg.sv
// Shared types and constants for the inverse IIR cascade.
// Q5.11 fixed-point helpers used by the datapath.
package iir_inv_cascade_pkg;

    localparam int WIDTH  = 16;
    localparam int Q_FRAC = 11;

    localparam logic [WIDTH-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [WIDTH-1:0] SAT_MIN = 16'h8000;
    localparam logic [WIDTH-1:0] ONE     = 16'h0800;

    typedef enum logic [1:0] {
        IDLE,
        MUL_A,
        MUL_G,
        DONE
    } state_e;

    function automatic logic [WIDTH-1:0] sat16(input logic signed [31:0] x);
        logic [WIDTH-1:0] r;
        if (x > 32'sd32767) begin
            r = SAT_MAX;
        end else if (x < -32'sd32768) begin
            r = SAT_MIN;
        end else begin
            r = x[WIDTH-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/iir_inv_cascade_q11_mul_sat.sv
// Shared Q5.11 multiplier: product, arithmetic shift, clamp.
// Purely combinational; the parent registers around it.
module q11_mul_sat
    import iir_inv_cascade_pkg::*;
(
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic        [WIDTH-1:0] p
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shf;

    // full product, floor-shift back to Q5.11, saturate
    always_comb begin
        prod = a * b;
        shf  = prod >>> Q_FRAC;
        p    = sat16(shf);
    end

endmodule

// File: rtl/iir_inv_cascade.sv
// Inverse of a 1..3 section first-order IIR cascade.
// One shared multiplier, two cycles per section.
module iir_inv_cascade
    import iir_inv_cascade_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g0,
    input  logic [WIDTH-1:0] g1,
    input  logic [WIDTH-1:0] g2,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    input  logic [3:0]       order,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready
);

    state_e state_q, state_d;

    logic [2:0][WIDTH-1:0] g_q, g_d;
    logic [2:0][WIDTH-1:0] a_q, a_d;
    logic [2:0][WIDTH-1:0] h_q, h_d;
    logic [WIDTH-1:0]      v_q, v_d;
    logic [WIDTH-1:0]      d_q, d_d;
    logic [WIDTH-1:0]      out_q, out_d;
    logic [1:0]            sec_q, sec_d;
    logic [3:0]            prev_ord_q, prev_ord_d;

    logic                  accept;
    logic                  ord_ok;
    logic [WIDTH-1:0]      sel_a, sel_g, sel_h;
    logic [WIDTH-1:0]      mul_x, mul_y, mul_p;
    logic signed [17:0]    diff;

    assign accept = (state_q == IDLE) && in_valid;
    assign ord_ok = (order != 4'd0) && (order <= 4'd3);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state: sections run top-down, invalid order skips to DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = ord_ok ? MUL_A : DONE;
            MUL_A:   state_d = MUL_G;
            MUL_G:   state_d = (sec_q == 2'd1) ? DONE : MUL_A;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // handshake outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        data_out  = out_q;
    end

    // coefficients and history of the active section
    always_comb begin
        sel_a = a_q[0];
        sel_g = g_q[0];
        sel_h = h_q[0];
        for (int k = 1; k < 3; k++) begin
            if (sec_q == 2'(k + 1)) begin
                sel_a = a_q[k];
                sel_g = g_q[k];
                sel_h = h_q[k];
            end
        end
    end

    // MUL_A forms a*h, MUL_G forms g*d
    always_comb begin
        mul_x = (state_q == MUL_G) ? sel_g : sel_a;
        mul_y = (state_q == MUL_G) ? d_q : sel_h;
    end

    q11_mul_sat u_mul (
        .a (mul_x),
        .b (mul_y),
        .p (mul_p)
    );

    // 18-bit subtract keeps v - a*h exact before clamping
    always_comb begin
        diff = {{2{v_q[15]}}, v_q} - {{2{mul_p[15]}}, mul_p};
    end

    // datapath next-state
    always_comb begin
        g_d        = g_q;
        a_d        = a_q;
        h_d        = h_q;
        v_d        = v_q;
        d_d        = d_q;
        out_d      = out_q;
        sec_d      = sec_q;
        prev_ord_d = prev_ord_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    g_d   = {g2, g1, g0};
                    a_d   = {a3, a2, a1};
                    v_d   = data_in;
                    sec_d = order[1:0];
                    if (ord_ok) begin
                        prev_ord_d = order;
                        if (order != prev_ord_q) h_d = '0;
                    end else begin
                        out_d = '0;
                    end
                end
            end
            MUL_A: begin
                d_d = sat16({{14{diff[17]}}, diff});
            end
            MUL_G: begin
                for (int k = 0; k < 3; k++) begin
                    if (sec_q == 2'(k + 1)) h_d[k] = v_q;
                end
                v_d = mul_p;
                if (sec_q == 2'd1) out_d = mul_p;
                else               sec_d = sec_q - 2'd1;
            end
            default: ;
        endcase
    end

    // datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            g_q        <= '0;
            a_q        <= '0;
            h_q        <= '0;
            v_q        <= '0;
            d_q        <= '0;
            out_q      <= '0;
            sec_q      <= '0;
            prev_ord_q <= 4'd1;
        end else begin
            g_q        <= g_d;
            a_q        <= a_d;
            h_q        <= h_d;
            v_q        <= v_d;
            d_q        <= d_d;
            out_q      <= out_d;
            sec_q      <= sec_d;
            prev_ord_q <= prev_ord_d;
        end
    end

endmodule

// File: tb/tb_iir_inv_cascade.sv
// Bench for iir_inv_cascade: vector table, scoreboard queue,
// directed backpressure / reset / round-trip sequences.
module tb_iir_inv_cascade;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] g0, g1, g2, a1, a2, a3;
    logic [3:0]  order;
    logic [15:0] data_out;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  ord;
        logic [15:0] din;
        logic [15:0] g0, g1, g2, a1, a2, a3;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] exp;
        int          tol;
    } sb_t;

    sb_t  sbq[$];
    vec_t tbl[11];

    iir_inv_cascade dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g0        (g0),
        .g1        (g1),
        .g2        (g2),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .order     (order),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [3:0] o, input logic [15:0] d,
                                input logic [15:0] q0, input logic [15:0] q1,
                                input logic [15:0] q2, input logic [15:0] c1,
                                input logic [15:0] c2, input logic [15:0] c3,
                                input logic [15:0] e);
        vec_t v;
        v.ord = o; v.din = d;
        v.g0 = q0; v.g1 = q1; v.g2 = q2;
        v.a1 = c1; v.a2 = c2; v.a3 = c3;
        v.exp = e;
        v.lat = (o >= 4'd1 && o <= 4'd3) ? 2 * int'(o) + 1 : 1;
        return v;
    endfunction

    function automatic int sat(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // forward section: y = sat((b*x)>>>11 + (a*yp)>>>11), b = 1.0
    function automatic int fsec(input int x, input int a, input int yp);
        return sat(((2048 * x) >>> 11) + ((a * yp) >>> 11));
    endfunction

    task automatic check16(input string name, input logic [15:0] act,
                           input logic [15:0] exp, input int tol);
        int dd;
        dd = $signed(act) - $signed(exp);
        checks++;
        if (dd > tol || dd < -tol) begin
            errors++;
            $display("FAIL %s: got %h expected %h (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        order = v.ord; data_in = v.din;
        g0 = v.g0; g1 = v.g1; g2 = v.g2;
        a1 = v.a1; a2 = v.a2; a3 = v.a3;
    endtask

    task automatic scramble();
        order = 4'($urandom); data_in = 16'($urandom);
        g0 = 16'($urandom); g1 = 16'($urandom); g2 = 16'($urandom);
        a1 = 16'($urandom); a2 = 16'($urandom); a3 = 16'($urandom);
    endtask

    task automatic sb_check(input string name);
        sb_t e;
        if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: output with empty scoreboard, got %h", name, data_out);
        end else begin
            e = sbq.pop_front();
            check16(name, data_out, e.exp, e.tol);
        end
    endtask

    // wait for out_valid; n0 cycles already elapsed since accept
    task automatic wait_out(input string name, input int lat, input int n0);
        int n;
        n = n0;
        while (!out_valid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL %s_timeout: out_valid never rose, got 0 expected 1", name);
            if (sbq.size() != 0) void'(sbq.pop_front());
        end else begin
            check_int({name, "_lat"}, n, lat);
            sb_check(name);
        end
    endtask

    task automatic do_sample(input string name, input vec_t v, input int tol);
        int n;
        sb_t e;
        n = 0;
        while (!in_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        drive(v);
        in_valid = 1'b1;
        e.exp = v.exp; e.tol = tol;
        sbq.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        wait_out(name, v.lat, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vb1, vb2, vr;
        sb_t  e;
        int   x, s1, s2, s3, n;

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        scramble();

        tbl[0]  = mk(4'd1,  16'h0800, 16'h0800, 16'h0, 16'h0, 16'h0400, 16'h0, 16'h0, 16'h0800);
        tbl[1]  = mk(4'd1,  16'h0800, 16'h0800, 16'h0, 16'h0, 16'h0400, 16'h0, 16'h0, 16'h0400);
        tbl[2]  = mk(4'd1,  16'h1000, 16'h7FFF, 16'h0, 16'h0, 16'h0000, 16'h0, 16'h0, 16'h7FFF);
        tbl[3]  = mk(4'd1,  16'hF000, 16'h7FFF, 16'h0, 16'h0, 16'h0000, 16'h0, 16'h0, 16'h8000);
        tbl[4]  = mk(4'd2,  16'h0200, 16'h0C00, 16'h1000, 16'h0, 16'h0400, 16'h0200, 16'h0, 16'h0600);
        tbl[5]  = mk(4'd0,  16'h1234, 16'h0C00, 16'h1000, 16'h0, 16'h0400, 16'h0200, 16'h0, 16'h0000);
        tbl[6]  = mk(4'd2,  16'h0200, 16'h0C00, 16'h1000, 16'h0, 16'h0400, 16'h0200, 16'h0, 16'h0180);
        tbl[7]  = mk(4'd15, 16'h7777, 16'h0C00, 16'h1000, 16'h0, 16'h0400, 16'h0200, 16'h0, 16'h0000);
        tbl[8]  = mk(4'd2,  16'h0000, 16'h0C00, 16'h1000, 16'h0, 16'h0400, 16'h0200, 16'h0, 16'hFC40);
        tbl[9]  = mk(4'd1,  16'h7FFF, 16'h0800, 16'h0, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h7FFF);
        tbl[10] = mk(4'd1,  16'h8000, 16'h0800, 16'h0, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h8000);

        // reset state
        #12;
        check_int("rst_in_ready", int'(in_ready), 1);
        check_int("rst_out_valid", int'(out_valid), 0);
        check16("rst_data_out", data_out, 16'h0000, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // vector table
        for (int i = 0; i < 11; i++) begin
            do_sample($sformatf("vec%0d", i), tbl[i], 0);
        end

        // backpressure: out_ready low, in_valid held high
        vb1 = mk(4'd1, 16'h0123, 16'h0800, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0123);
        vb2 = mk(4'd1, 16'h0456, 16'h0800, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0456);
        out_ready = 1'b0;
        drive(vb1);
        in_valid = 1'b1;
        e.exp = vb1.exp; e.tol = 0;
        sbq.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out("bp_first", 3, 1);
        drive(vb2);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check16("bp_hold_data", data_out, 16'h0123, 0);
            check_int("bp_in_ready", int'(in_ready), 0);
            check_int("bp_out_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_int("bp_release_valid", int'(out_valid), 0);
        check_int("bp_release_ready", int'(in_ready), 1);
        e.exp = vb2.exp;
        sbq.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        wait_out("bp_second", 3, 1);
        @(posedge clk); #1;

        // reset while in MUL_G aborts the sample and clears history
        drive(vb2);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_int("mid_rst_out_valid", int'(out_valid), 0);
        check_int("mid_rst_in_ready", int'(in_ready), 1);
        check16("mid_rst_data_out", data_out, 16'h0000, 0);
        @(posedge clk); #1;
        check_int("mid_rst_no_out", int'(out_valid), 0);
        @(negedge clk);
        reset = 1'b1;
        do_sample("post_rst", tbl[0], 0);

        // round trip through a forward order-3 cascade
        s1 = 0; s2 = 0; s3 = 0;
        for (int i = 0; i < 24; i++) begin
            x  = int'($urandom_range(0, 2047)) - 1024;
            s1 = fsec(x, 512, s1);
            s2 = fsec(s1, -512, s2);
            s3 = fsec(s2, 256, s3);
            vr = mk(4'd3, 16'(s3), 16'h0800, 16'h0800, 16'h0800,
                    16'h0200, 16'hFE00, 16'h0100, 16'(x));
            do_sample($sformatf("rt%0d", i), vr, 2);
        end

        n = sbq.size();
        check_int("sb_empty", n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
